// File: rtl/aes_mix_columns_iter.sv
// aes_mix_columns_iter
// Iterative MixColumns / InvMixColumns engine for a NumCols-column AES-style
// state. A state is accepted on the input handshake, transformed NumLanes
// columns per clock in an internal register, and presented on the output
// handshake. The inverse transform reuses the forward datapath after a cheap
// per-column premultiply step.
//
// Optional feature: define AES_MIXCOL_CLEAR_EN to add the clear_i port, a
// synchronous wipe of the state register, column counter and latched op.

module aes_mix_columns_iter #(
  parameter int NumCols  = 4,
  parameter int NumLanes = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef AES_MIXCOL_CLEAR_EN
  input  logic                  clear_i,
`endif
  input  logic [1:0]            op_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [32*NumCols-1:0] data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [32*NumCols-1:0] data_o
);

  localparam int StateW = 32 * NumCols;
  localparam int CntW   = $clog2(NumCols) + 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(NumCols);
  localparam logic [CntW-1:0] CntStep  = CntW'(NumLanes);

  localparam logic [1:0] OpInv = 2'b10;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Reject configurations the column scheduler cannot cover exactly.
  if (NumCols < 4 || NumCols > 8 || NumLanes < 1 || (NumCols % NumLanes) != 0)
  begin : gen_bad_params
    $error("aes_mix_columns_iter: NumCols must be 4..8 and divisible by NumLanes");
  end

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11B.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column: o_r = 2*b_r ^ 3*b_{r+1} ^ b_{r+2} ^ b_{r+3}.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0]  b [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      b[r] = col[8*r +: 8];
    end
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = xtime(b[r]) ^ xtime(b[(r+1)%4]) ^ b[(r+1)%4]
                    ^ b[(r+2)%4] ^ b[(r+3)%4];
    end
    return res;
  endfunction

  // Premultiply so that a following forward MixColumns yields the inverse:
  // b0,b2 ^= 4*(b0^b2); b1,b3 ^= 4*(b1^b3).
  function automatic logic [31:0] inv_pre(input logic [31:0] col);
    logic [7:0] u;
    logic [7:0] v;
    u = xtime(xtime(col[7:0]  ^ col[23:16]));
    v = xtime(xtime(col[15:8] ^ col[31:24]));
    return {col[31:24] ^ v, col[23:16] ^ u, col[15:8] ^ v, col[7:0] ^ u};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [StateW-1:0] data_q,  data_d;
  logic [CntW-1:0]   cnt_q,   cnt_d;
  logic [1:0]        op_q,    op_d;

  logic              op_inv;
  logic [CntW-1:0]   cnt_next;
  logic [31:0]       lane_in  [NumLanes];
  logic [31:0]       lane_out [NumLanes];

  assign op_inv   = (op_q == OpInv);
  assign cnt_next = cnt_q + CntStep;

  // Lane datapath: pick columns cnt..cnt+NumLanes-1 and transform them.
  always_comb begin
    for (int l = 0; l < NumLanes; l++) begin
      // NOTE: every always_comb output gets a default before any conditional
      // assignment so no path leaves it unassigned and no latch is inferred.
      lane_in[l] = '0;
      for (int c = 0; c < NumCols; c++) begin
        if (c == int'(cnt_q) + l) begin
          lane_in[l] = data_q[32*c +: 32];
        end
      end
      lane_out[l] = mix_fwd(op_inv ? inv_pre(lane_in[l]) : lane_in[l]);
    end
  end

  // Next-state logic: handshake FSM plus in-place column write-back.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          data_d  = data_i;
          op_d    = op_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        for (int c = 0; c < NumCols; c++) begin
          for (int l = 0; l < NumLanes; l++) begin
            if (c == int'(cnt_q) + l) begin
              data_d[32*c +: 32] = lane_out[l];
            end
          end
        end
        cnt_d = cnt_next;
        if (cnt_next == CntLast) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef AES_MIXCOL_CLEAR_EN
    // Wipe dominates any handshake in the same cycle.
    if (clear_i) begin
      state_d = StIdle;
      data_d  = '0;
      cnt_d   = '0;
      op_d    = '0;
    end
`endif
  end

  // State, data, counter and op registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      // NOTE: the wide state register is reset too, so an aborted operation
      // leaves no key-dependent residue behind; sequential state uses <= only.
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Outputs: result masked to zero whenever it is not being offered.
  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign data_o      = out_valid_o ? data_q : '0;

endmodule
